// File: rtl/count_tick_gen_if.sv
// Button inputs and pacing outputs of the LED-counter tick generator.
// The slave modport is the generator; the master modport is the board/bench side.
interface count_tick_gen_if;
  logic btn_run;
  logic btn_step;
  logic tick;
  logic running;
  logic heartbeat;

  modport master (
    output btn_run,
    output btn_step,
    input  tick,
    input  running,
    input  heartbeat
  );

  modport slave (
    input  btn_run,
    input  btn_step,
    output tick,
    output running,
    output heartbeat
  );
endinterface

// File: rtl/count_tick_gen.sv
// Paces the 4-bit LED counter: prescaled count-enable tick plus debounced
// run/pause toggle and single-step buttons.
module count_tick_gen #(
  parameter int unsigned DIV        = 50000000,
  parameter int unsigned DIV_W      = 26,
  parameter int unsigned DEB_CYCLES = 1000000,
  parameter int unsigned DEB_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  count_tick_gen_if.slave   bus
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam int unsigned      BTN_RUN  = 0;
  localparam int unsigned      BTN_STEP = 1;

  typedef enum logic {
    S_RUNNING = 1'b0,
    S_PAUSED  = 1'b1
  } state_t;

  logic [1:0]       btn_raw_s;
  logic [1:0]       sync1_q;
  logic [1:0]       sync2_q;
  logic [1:0]       deb_q;
  logic [1:0]       deb_d;
  logic [1:0]       press_q;
  logic [1:0]       press_d;
  logic [DEB_W-1:0] deb_cnt_q [2];
  logic [DEB_W-1:0] deb_cnt_d [2];

  state_t           state_q;
  state_t           state_d;
  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             tick_q;
  logic             tick_d;
  logic             heartbeat_q;
  logic             heartbeat_d;

  assign btn_raw_s = {bus.btn_step, bus.btn_run};

  // Debounce: a level change is accepted after DEB_CYCLES stable cycles; press fires on the accepting edge of a rise.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      deb_d[b]     = deb_q[b];
      press_d[b]   = 1'b0;
      deb_cnt_d[b] = {DEB_W{1'b0}};
      if (sync2_q[b] != deb_q[b]) begin
        if (deb_cnt_q[b] == DEB_LAST) begin
          deb_d[b]   = sync2_q[b];
          press_d[b] = sync2_q[b];
        end else begin
          deb_cnt_d[b] = deb_cnt_q[b] + DEB_W'(1);
        end
      end else begin
        deb_cnt_d[b] = {DEB_W{1'b0}};
      end
    end
  end

  // Synchronizer, debounce and press-pulse registers for both buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      deb_q   <= 2'b00;
      press_q <= 2'b00;
      for (int b = 0; b < 2; b++) begin
        deb_cnt_q[b] <= {DEB_W{1'b0}};
      end
    end else begin
      sync1_q <= btn_raw_s;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int b = 0; b < 2; b++) begin
        deb_cnt_q[b] <= deb_cnt_d[b];
      end
    end
  end

  // Run/pause FSM with prescaler and tick source selection.
  always_comb begin
    state_d   = state_q;
    div_cnt_d = {DIV_W{1'b0}};
    tick_d    = 1'b0;
    case (state_q)
      S_RUNNING: begin
        if (div_cnt_q == DIV_LAST) begin
          tick_d    = 1'b1;
          div_cnt_d = {DIV_W{1'b0}};
        end else begin
          tick_d    = 1'b0;
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
        // A pause landing on the wrap edge still lets that tick out.
        if (press_q[BTN_RUN]) begin
          state_d   = S_PAUSED;
          div_cnt_d = {DIV_W{1'b0}};
        end else begin
          state_d = S_RUNNING;
        end
      end
      S_PAUSED: begin
        if (press_q[BTN_RUN]) begin
          state_d = S_RUNNING;
        end else if (press_q[BTN_STEP]) begin
          tick_d = 1'b1;
        end else begin
          state_d = S_PAUSED;
        end
      end
      default: begin
        state_d = S_RUNNING;
      end
    endcase
    heartbeat_d = heartbeat_q ^ tick_d;
  end

  // FSM state, prescaler and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUNNING;
      div_cnt_q   <= {DIV_W{1'b0}};
      tick_q      <= 1'b0;
      heartbeat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      tick_q      <= tick_d;
      heartbeat_q <= heartbeat_d;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.running   = (state_q == S_RUNNING);
  assign bus.heartbeat = heartbeat_q;

endmodule

// File: tb/tb_count_tick_gen.sv
// Directed bench for count_tick_gen with DIV=4 and DEB_CYCLES=3.
module tb_count_tick_gen;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  logic hb_exp;
  logic [5:0] bounce_pat;

  always #5 clk = ~clk;

  count_tick_gen_if bus ();

  count_tick_gen #(
    .DIV        (4),
    .DIV_W      (3),
    .DEB_CYCLES (3),
    .DEB_W      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply buttons for one clock, then check outputs on the following falling edge.
  task automatic cyc_step(input string tag, input logic run_b, input logic step_b,
                          input logic exp_tick, input logic exp_run);
    bus.btn_run  = run_b;
    bus.btn_step = step_b;
    @(negedge clk);
    if (exp_tick) hb_exp = ~hb_exp;
    chk({tag, "/tick"},      32'(bus.tick),      32'(exp_tick));
    chk({tag, "/running"},   32'(bus.running),   32'(exp_run));
    chk({tag, "/heartbeat"}, 32'(bus.heartbeat), 32'(hb_exp));
  endtask

  task automatic idle_cycle();
    cyc++;
    cyc_step("idle", 1'b0, 1'b0, (cyc % 4) == 0, 1'b1);
  endtask

  initial begin
    rst          = 1'b1;
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    hb_exp       = 1'b0;
    bounce_pat   = 6'b011011;
    repeat (2) @(negedge clk);
    chk("reset/tick",      32'(bus.tick),      32'd0);
    chk("reset/running",   32'(bus.running),   32'd1);
    chk("reset/heartbeat", 32'(bus.heartbeat), 32'd0);
    rst = 1'b0;

    for (int c = 1; c <= 12; c++) begin
      cyc_step("free", 1'b0, 1'b0, (c % 4) == 0, 1'b1);
    end
    cyc = 12;

    for (int i = 0; i < 12; i++) begin
      cyc++;
      cyc_step("bounce", (i < 6) ? bounce_pat[i] : 1'b0, 1'b0, (cyc % 4) == 0, 1'b1);
    end

    // Pause lands off the wrap edge here; the collision case comes later.
    while (((cyc + 6) % 4) == 0) idle_cycle();
    for (int k = 1; k <= 14; k++) begin
      cyc_step("pause", k <= 6, 1'b0, (k <= 6) && (((cyc + k) % 4) == 0), k < 6);
    end

    for (int k = 1; k <= 14; k++) begin
      cyc_step("step", 1'b0, k <= 5, k == 6, 1'b0);
    end

    for (int k = 1; k <= 16; k++) begin
      cyc_step("resume", k <= 5, 1'b0, (k >= 10) && (((k - 6) % 4) == 0), k >= 6);
    end
    cyc = 10;

    while (((cyc + 6) % 4) != 0) idle_cycle();
    for (int k = 1; k <= 14; k++) begin
      cyc_step("collide", k <= 5, 1'b0, (k <= 6) && (((cyc + k) % 4) == 0), k < 6);
    end

    for (int k = 1; k <= 16; k++) begin
      cyc_step("both", k <= 5, k <= 5, (k >= 10) && (((k - 6) % 4) == 0), k >= 6);
    end
    cyc = 10;

    while (!(((cyc % 4) == 2) && (hb_exp == 1'b1))) idle_cycle();
    rst = 1'b1;
    #1;
    chk("midrst/tick",      32'(bus.tick),      32'd0);
    chk("midrst/running",   32'(bus.running),   32'd1);
    chk("midrst/heartbeat", 32'(bus.heartbeat), 32'd0);
    hb_exp = 1'b0;
    repeat (2) @(negedge clk);
    chk("inrst/tick", 32'(bus.tick), 32'd0);
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      cyc_step("post_rst", 1'b0, 1'b0, (c % 4) == 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
